sync_fifo_32x512: RTL and testbench

- Single-clock, first-word-fall-through (FWFT) FIFO, 32 bits wide and 512 words deep.
- Buffers PC-to-FPGA command words for the application. The application sees valid = !empty, the data on dout, and acknowledges with rden.
- almost_full is the backpressure signal returned to the upstream writer; it stops the writer before the FIFO overruns.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_fifo_32x512_if.sv | 38 +++
 rtl/fifo_dpram.sv | 38 +++
 rtl/sync_fifo_32x512.sv | 100 ++++++++++
 tb/tb_sync_fifo_32x512.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: boolean constants, default geometry and the ceiling-log2 helper.
package fifo_pkg;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 512;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_32x512_if.sv
// FIFO data/handshake bundle; the master drives writes and read acknowledges.
// Status signals exist only when FIFO_STATUS_EN is defined.
interface sync_fifo_32x512_if #(
  parameter int WIDTH = fifo_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = fifo_pkg::DEFAULT_DEPTH
);
  logic [WIDTH-1:0] din;
  logic             wren;
  logic             full;
  logic             almost_full;
  logic             rden;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             almost_empty;
`ifdef FIFO_STATUS_EN
  logic                               overflow;
  logic                               underflow;
  logic [fifo_pkg::clog2(DEPTH):0]    data_count;

  modport master (
    output din, wren, rden,
    input  full, almost_full, dout, empty, almost_empty, overflow, underflow, data_count
  );
  modport slave (
    input  din, wren, rden,
    output full, almost_full, dout, empty, almost_empty, overflow, underflow, data_count
  );
`else
  modport master (
    output din, wren, rden,
    input  full, almost_full, dout, empty, almost_empty
  );
  modport slave (
    input  din, wren, rden,
    output full, almost_full, dout, empty, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port WIDTH x DEPTH memory; registered, write-first read port so a word
// written to the address being read this edge is returned directly.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      wr_en_i,
  input  logic [clog2(DEPTH)-1:0]   wr_addr_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      rd_en_i,
  input  logic [clog2(DEPTH)-1:0]   rd_addr_i,
  output logic [WIDTH-1:0]          rd_data_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is reset; the array contents are never cleared.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_32x512.sv
// Single-clock first-word-fall-through FIFO with registered flags derived from next count.
// Define FIFO_STATUS_EN to add overflow/underflow pulses and data_count.
module sync_fifo_32x512
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic               CLK,
  input logic               RESET_N,
  sync_fifo_32x512_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, almost_empty_q, full_q, almost_full_q;
  logic             wr_acc_s, rd_acc_s, ram_rd_en_s;
  logic [WIDTH-1:0] dout_s;

  always_comb begin
    wr_acc_s = bus.wren & ~full_q;
    rd_acc_s = bus.rden & ~empty_q;
    wr_ptr_d = wr_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_acc_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // The head word changes on a pop, or when the first word lands in an empty FIFO.
    ram_rd_en_s = (count_d != '0) && (rd_acc_s || empty_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= TRUE;
      almost_empty_q <= TRUE;
      full_q         <= FALSE;
      almost_full_q  <= FALSE;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= CNT_ONE);
      full_q         <= (count_d == CNT_FULL);
      almost_full_q  <= (count_d >= CNT_AFULL);
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .wr_en_i   (wr_acc_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.din),
    .rd_en_i   (ram_rd_en_s),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (dout_s)
  );

  assign bus.dout         = dout_s;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;

`ifdef FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  // Sticky for one cycle only: flags a request that arrived while it could not be honoured.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      overflow_q  <= FALSE;
      underflow_q <= FALSE;
    end else begin
      overflow_q  <= bus.wren & full_q;
      underflow_q <= bus.rden & empty_q;
    end
  end

  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.data_count = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_32x512.sv
// Scoreboard bench for sync_fifo_32x512: a queue of expected words checked on every pop
// and used to derive the expected flags.
module tb_sync_fifo_32x512;
  import fifo_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pop = 32'h0;
  logic [31:0] pat;

  sync_fifo_32x512_if bus ();

  sync_fifo_32x512 dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = exp_q.size();
    check_eq({tag, "/empty"},        bus.empty,        n == 0);
    check_eq({tag, "/almost_empty"}, bus.almost_empty, n <= 1);
    check_eq({tag, "/full"},         bus.full,         n == DEPTH);
    check_eq({tag, "/almost_full"},  bus.almost_full,  n >= DEPTH - 1);
    if (n > 0) begin
      check_eq({tag, "/head"}, bus.dout, exp_q[0]);
    end
`ifdef FIFO_STATUS_EN
    check_eq({tag, "/data_count"}, bus.data_count, n);
`endif
  endtask

  // One clock of stimulus; called and returns just after a falling edge.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd);
    int   n;
    logic wa, ra;
    n  = exp_q.size();
    wa = wr && (n < DEPTH);
    ra = rd && (n > 0);
    if (ra) begin
      check_eq("pop", bus.dout, exp_q[0]);
      last_pop = exp_q.pop_front();
    end
    if (wa) begin
      exp_q.push_back(d);
    end
    bus.wren = wr;
    bus.din  = d;
    bus.rden = rd;
    @(posedge clk);
    @(negedge clk);
    bus.wren = 1'b0;
    bus.rden = 1'b0;
  endtask

  initial begin
    bus.din  = 32'h0;
    bus.wren = 1'b0;
    bus.rden = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_flags("reset");
    check_eq("reset/dout", bus.dout, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    step(1'b0, 32'h0, 1'b1);
    check_flags("idle_rden");
    check_eq("idle_rden/dout", bus.dout, 32'h0);
`ifdef FIFO_STATUS_EN
    check_eq("underflow", bus.underflow, 1'b1);
`endif

    step(1'b1, 32'h0000_0000, 1'b0);
    check_flags("w1");
    step(1'b1, 32'h0012_0000, 1'b0);
    step(1'b1, 32'h3C23_D70A, 1'b0);
    check_flags("w3");
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    check_flags("drain3");
    check_eq("hold_last", bus.dout, 32'h3C23_D70A);
    check_eq("hold_last_model", bus.dout, last_pop);

    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 32'(i), 1'b0);
    check_flags("fill511");
    step(1'b1, 32'(DEPTH - 1), 1'b0);
    check_flags("full");
    step(1'b1, 32'h0000_DEAD, 1'b0);
    check_flags("overrun");
`ifdef FIFO_STATUS_EN
    check_eq("overflow", bus.overflow, 1'b1);
`endif
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1);
    check_flags("drained");

    pat = 32'h1000_0000;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pat, 1'b0);
      pat = pat + 32'h1;
    end
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, pat, 1'b1);
      pat = pat + 32'h1;
      check_flags("stream");
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check_flags("stream_drain");

    step(1'b1, 32'hA5A5_0001, 1'b1);
    check_flags("empty_wr_rd");
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b1, pat, 1'b0);
      pat = pat + 32'h1;
    end
    check_flags("refull");
    step(1'b1, 32'hBAD0_0000, 1'b1);
    check_flags("full_wr_rd");

    for (int i = 0; i < DEPTH - 1 - 200; i++) step(1'b0, 32'h0, 1'b1);
    check_flags("mid200");

    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_flags("async_rst");
    check_eq("async_rst/dout", bus.dout, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 32'h0000_0940, 1'b0);
    check_flags("post_rst");
    check_eq("post_rst/dout", bus.dout, 32'h0000_0940);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
